// File: rtl/microwave_mode_fsm.sv
// Mode sequencer for the microwave: turns button pulses, door state and remaining
// cook time into the mode bus, heater enable, finish buzzer and clear-time request.
module microwave_mode_fsm #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FINISH_SEC = 3,
    parameter int BEEP_DIV   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnC,
    input  logic        btnL,
    input  logic        door_open,
    input  logic [13:0] run_time,
    output logic [2:0]  mode,
    output logic        heater_en,
    output logic        buzzer,
    output logic        clear_time
);

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_SET    = 3'b001;
    localparam logic [2:0] ST_RUN    = 3'b010;
    localparam logic [2:0] ST_STOP   = 3'b011;
    localparam logic [2:0] ST_FINISH = 3'b100;

    localparam int FIN_CYC   = FINISH_SEC * CLK_HZ;
    localparam int FCNT_W    = (FIN_CYC > 1) ? $clog2(FIN_CYC) : 1;
    localparam int BEEP_HALF = (CLK_HZ / (2 * BEEP_DIV) > 1) ? CLK_HZ / (2 * BEEP_DIV) : 1;
    localparam int BCNT_W    = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

    localparam logic [FCNT_W-1:0] FIN_MAX  = FCNT_W'(FIN_CYC - 1);
    localparam logic [BCNT_W-1:0] BEEP_MAX = BCNT_W'(BEEP_HALF - 1);

    logic [2:0]        mode_q, mode_d;
    logic              heater_q, heater_d;
    logic              buzzer_q, buzzer_d;
    logic              clear_q, clear_d;
    logic [FCNT_W-1:0] fin_cnt_q, fin_cnt_d;
    logic [BCNT_W-1:0] beep_cnt_q, beep_cnt_d;

    logic any_btn_s;
    logic time_left_s;
    logic can_run_s;
    logic timeout_s;

    assign any_btn_s   = btnU | btnD | btnC | btnL;
    assign time_left_s = (run_time != 14'd0);
    assign can_run_s   = time_left_s & ~door_open;
    assign timeout_s   = (fin_cnt_q == FIN_MAX);

    // Next-mode decode with per-state priorities
    always_comb begin
        mode_d = ST_IDLE;
        case (mode_q)
            ST_IDLE: begin
                if (btnU | btnD) mode_d = ST_SET;
                else             mode_d = ST_IDLE;
            end
            ST_SET: begin
                if (btnL)                   mode_d = ST_IDLE;
                else if (btnC && can_run_s) mode_d = ST_RUN;
                else                        mode_d = ST_SET;
            end
            ST_RUN: begin
                // Expiry of the cook time wins over every button and the door
                if (!time_left_s)                  mode_d = ST_FINISH;
                else if (door_open | btnL | btnC)  mode_d = ST_STOP;
                else                               mode_d = ST_RUN;
            end
            ST_STOP: begin
                if (btnL)                   mode_d = ST_IDLE;
                else if (btnC && can_run_s) mode_d = ST_RUN;
                else if (btnC)              mode_d = ST_STOP;
                else if (btnU | btnD)       mode_d = ST_SET;
                else                        mode_d = ST_STOP;
            end
            ST_FINISH: begin
                if (any_btn_s | timeout_s) mode_d = ST_IDLE;
                else                       mode_d = ST_FINISH;
            end
            default: mode_d = ST_IDLE;
        endcase
    end

    // Output and finish-timer next values, all derived from the next mode
    always_comb begin
        heater_d   = (mode_d == ST_RUN) & ~door_open;
        clear_d    = (mode_d == ST_IDLE) & ((mode_q == ST_SET) | (mode_q == ST_STOP));
        fin_cnt_d  = '0;
        beep_cnt_d = '0;
        buzzer_d   = 1'b0;
        if (mode_d == ST_FINISH && mode_q != ST_FINISH) begin
            buzzer_d = 1'b1;
        end else if (mode_d == ST_FINISH) begin
            fin_cnt_d = timeout_s ? fin_cnt_q : fin_cnt_q + 1'b1;
            if (beep_cnt_q == BEEP_MAX) begin
                beep_cnt_d = '0;
                buzzer_d   = ~buzzer_q;
            end else begin
                beep_cnt_d = beep_cnt_q + 1'b1;
                buzzer_d   = buzzer_q;
            end
        end else begin
            buzzer_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= ST_IDLE;
            heater_q   <= 1'b0;
            buzzer_q   <= 1'b0;
            clear_q    <= 1'b0;
            fin_cnt_q  <= '0;
            beep_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            heater_q   <= heater_d;
            buzzer_q   <= buzzer_d;
            clear_q    <= clear_d;
            fin_cnt_q  <= fin_cnt_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign mode       = mode_q;
    assign heater_en  = heater_q;
    assign buzzer     = buzzer_q;
    assign clear_time = clear_q;

endmodule

// File: tb/tb_microwave_mode_fsm.sv
// Directed bench for microwave_mode_fsm using a fast tick base (CLK_HZ=20).
module tb_microwave_mode_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        btnU, btnD, btnC, btnL, door_open;
    logic [13:0] run_time;
    logic [2:0]  mode;
    logic        heater_en, buzzer, clear_time;

    int checks = 0;
    int errors = 0;

    microwave_mode_fsm #(.CLK_HZ(20), .FINISH_SEC(3), .BEEP_DIV(2)) dut (
        .clk(clk), .reset(reset),
        .btnU(btnU), .btnD(btnD), .btnC(btnC), .btnL(btnL),
        .door_open(door_open), .run_time(run_time),
        .mode(mode), .heater_en(heater_en), .buzzer(buzzer), .clear_time(clear_time)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_u();
        btnU = 1'b1; tick(); btnU = 1'b0;
    endtask
    task automatic pulse_d();
        btnD = 1'b1; tick(); btnD = 1'b0;
    endtask
    task automatic pulse_c();
        btnC = 1'b1; tick(); btnC = 1'b0;
    endtask
    task automatic pulse_l();
        btnL = 1'b1; tick(); btnL = 1'b0;
    endtask

    initial begin
        reset = 1'b1; btnU = 1'b0; btnD = 1'b0; btnC = 1'b0; btnL = 1'b0;
        door_open = 1'b0; run_time = 14'd0;
        #2;
        check("rst_mode", {5'd0, mode}, 8'd0);
        check("rst_heater", {7'd0, heater_en}, 8'd0);
        check("rst_buzzer", {7'd0, buzzer}, 8'd0);
        check("rst_clear", {7'd0, clear_time}, 8'd0);
        #10 reset = 1'b0;
        tick();
        check("idle_hold", {5'd0, mode}, 8'd0);

        // 1: IDLE -> SET -> RUN
        pulse_u();
        check("t1_set", {5'd0, mode}, 8'd1);
        run_time = 14'd60;
        pulse_c();
        check("t1_run", {5'd0, mode}, 8'd2);
        check("t1_heat", {7'd0, heater_en}, 8'd1);
        pulse_u();
        check("t1_run_ign_u", {5'd0, mode}, 8'd2);

        // 2: door handling
        door_open = 1'b1;
        tick();
        check("t2_stop", {5'd0, mode}, 8'd3);
        check("t2_heat_off", {7'd0, heater_en}, 8'd0);
        pulse_c();
        check("t2_stop_door", {5'd0, mode}, 8'd3);
        door_open = 1'b0;
        pulse_c();
        check("t2_resume", {5'd0, mode}, 8'd2);
        check("t2_heat_on", {7'd0, heater_en}, 8'd1);

        // 3: time expiry beats same-cycle btnC, buzzer cadence, timeout
        run_time = 14'd0;
        pulse_c();
        check("t3_finish", {5'd0, mode}, 8'd4);
        check("t3_buz0", {7'd0, buzzer}, 8'd1);
        check("t3_heat", {7'd0, heater_en}, 8'd0);
        for (int k = 1; k < 60; k++) begin
            tick();
            check($sformatf("t3_mode_%0d", k), {5'd0, mode}, 8'd4);
            check($sformatf("t3_buz_%0d", k), {7'd0, buzzer}, ((k / 5) % 2 == 0) ? 8'd1 : 8'd0);
            check($sformatf("t3_clr_%0d", k), {7'd0, clear_time}, 8'd0);
        end
        tick();
        check("t3_timeout", {5'd0, mode}, 8'd0);
        check("t3_buz_off", {7'd0, buzzer}, 8'd0);
        check("t3_no_clr", {7'd0, clear_time}, 8'd0);
        tick();
        check("t3_no_clr2", {7'd0, clear_time}, 8'd0);

        // 4: SET with zero time, cancel
        pulse_u();
        check("t4_set", {5'd0, mode}, 8'd1);
        pulse_c();
        check("t4_set_zero", {5'd0, mode}, 8'd1);
        check("t4_heat", {7'd0, heater_en}, 8'd0);
        pulse_l();
        check("t4_cancel", {5'd0, mode}, 8'd0);
        check("t4_clr", {7'd0, clear_time}, 8'd1);
        tick();
        check("t4_clr_end", {7'd0, clear_time}, 8'd0);

        // 5: STOP -> SET, early FINISH exit by button
        pulse_u();
        run_time = 14'd60;
        pulse_c();
        pulse_c();
        check("t5_stop", {5'd0, mode}, 8'd3);
        pulse_d();
        check("t5_set", {5'd0, mode}, 8'd1);
        check("t5_no_clr", {7'd0, clear_time}, 8'd0);
        pulse_c();
        check("t5_run", {5'd0, mode}, 8'd2);
        run_time = 14'd0;
        tick();
        check("t5_finish", {5'd0, mode}, 8'd4);
        for (int k = 1; k <= 6; k++) tick();
        check("t5_fin_k6", {5'd0, mode}, 8'd4);
        check("t5_buz_k6", {7'd0, buzzer}, 8'd0);
        pulse_u();
        check("t5_exit", {5'd0, mode}, 8'd0);
        check("t5_exit_buz", {7'd0, buzzer}, 8'd0);
        check("t5_exit_clr", {7'd0, clear_time}, 8'd0);

        // 6: asynchronous reset mid-RUN and mid-FINISH
        pulse_u();
        run_time = 14'd60;
        pulse_c();
        check("t6_run", {7'd0, heater_en}, 8'd1);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_mode", {5'd0, mode}, 8'd0);
        check("t6_rst_heat", {7'd0, heater_en}, 8'd0);
        #1 reset = 1'b0;
        tick();
        check("t6_after_rst", {5'd0, mode}, 8'd0);
        pulse_u();
        pulse_c();
        run_time = 14'd0;
        tick();
        check("t6_finish", {5'd0, mode}, 8'd4);
        check("t6_buz_on", {7'd0, buzzer}, 8'd1);
        #1 reset = 1'b1;
        #1;
        check("t6_rst2_mode", {5'd0, mode}, 8'd0);
        check("t6_rst2_buz", {7'd0, buzzer}, 8'd0);
        check("t6_rst2_clr", {7'd0, clear_time}, 8'd0);
        #1 reset = 1'b0;
        tick();
        check("t6_idle", {5'd0, mode}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
